// File: rtl/fifo_txuart.sv
// 8N1 UART transmitter that drains a show-ahead FIFO: one byte per frame,
// back-to-back frames with no idle gap while the FIFO stays non-empty.
module fifo_txuart #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int BW              = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_fifo_empty,
  input  logic [BW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  output logic          o_uart_tx,
  output logic          o_busy
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD + 1);
  localparam int IW = $clog2(BW + 1);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLOCKS_PER_BAUD);
  localparam logic [IW-1:0] LAST_BIT    = IW'(BW - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [IW-1:0] r_bit_idx, w_bit_idx_nxt;
  logic [BW-1:0] r_shreg, w_shreg_nxt, w_shreg_shifted;
  logic          r_tx, w_tx_nxt;
  logic          w_period_end;
  logic          w_load;

  // FIFO side: a word is offered while i_fifo_empty is low; o_fifo_rd high
  // takes it on that same clock edge, only when idle or on the final stop cycle.
  assign w_period_end    = (r_baud_cnt == CW'(1));
  assign w_load          = !i_reset && !i_fifo_empty &&
                           (r_state == IDLE || (r_state == STOP && w_period_end));
  assign w_shreg_shifted = r_shreg >> 1;

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shreg_nxt    = r_shreg;
    w_tx_nxt       = r_tx;
    if (r_state != IDLE) begin
      w_baud_cnt_nxt = r_baud_cnt - CW'(1);
    end
    case (r_state)
      START: begin
        if (w_period_end) begin
          w_state_nxt    = DATA;
          w_baud_cnt_nxt = BAUD_RELOAD;
          w_bit_idx_nxt  = '0;
          w_tx_nxt       = r_shreg[0];
        end
      end
      DATA: begin
        if (w_period_end) begin
          w_baud_cnt_nxt = BAUD_RELOAD;
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shreg_nxt   = w_shreg_shifted;
            w_bit_idx_nxt = r_bit_idx + IW'(1);
            w_tx_nxt      = w_shreg_shifted[0];
          end
        end
      end
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_period_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
    // A pop always wins: it overrides the STOP->IDLE exit for zero-gap frames.
    if (w_load) begin
      w_shreg_nxt    = i_fifo_data;
      w_state_nxt    = START;
      w_baud_cnt_nxt = BAUD_RELOAD;
      w_tx_nxt       = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign o_fifo_rd = w_load;
  assign o_uart_tx = r_tx;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_txuart.sv
// Bench for fifo_txuart: two instances (4 and 2 clocks per bit) fed by FIFO
// models, checked every cycle against a frame-schedule model and a receiver.
module tb_fifo_txuart;

  localparam int BW    = 8;
  localparam int CPB_A = 4;
  localparam int CPB_B = 2;
  localparam int RING  = 256;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst;
  logic [1:0]    empty;
  logic [BW-1:0] data_a, data_b;
  logic          rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;
  logic [1:0]    rd_v, tx_v, busy_v;

  assign rd_v   = {rd_b, rd_a};
  assign tx_v   = {tx_b, tx_a};
  assign busy_v = {busy_b, busy_a};

  fifo_txuart #(.CLOCKS_PER_BAUD(CPB_A), .BW(BW)) u_dut_a (
    .i_clk(clk), .i_reset(rst[0]), .i_fifo_empty(empty[0]), .i_fifo_data(data_a),
    .o_fifo_rd(rd_a), .o_uart_tx(tx_a), .o_busy(busy_a)
  );

  fifo_txuart #(.CLOCKS_PER_BAUD(CPB_B), .BW(BW)) u_dut_b (
    .i_clk(clk), .i_reset(rst[1]), .i_fifo_empty(empty[1]), .i_fifo_data(data_b),
    .o_fifo_rd(rd_b), .o_uart_tx(tx_b), .o_busy(busy_b)
  );

  // FIFO contents per instance, and the expected line level per future cycle
  logic [BW-1:0] fifo_mem [2][RING];
  int            fifo_rp  [2];
  int            fifo_wp  [2];
  logic          line_mem [2][RING];
  int            line_rp  [2];
  int            line_wp  [2];
  logic [1:0]    rst_req, prev_rd, prev_rst, prev_load;
  logic [BW-1:0] prev_head [2];
  int            busy_cnt [2];
  int            rd_cnt   [2];
  int            cyc;
  int            n_vec, n_err;

  // scoreboard for instance B: bytes written, in order
  logic [BW-1:0] exp_q [$];
  bit            rx_on;
  int            rx_t;
  int            rx_cnt;
  logic [BW-1:0] rx_byte;

  task automatic check_bit(input string tag, input int g, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] cyc=%0d observed=%b expected=%b", tag, g, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int g, input logic [BW-1:0] b);
    fifo_mem[g][fifo_wp[g] % RING] = b;
    fifo_wp[g]++;
    if (g == 1) exp_q.push_back(b);
  endtask

  // a frame is start(0), BW data bits LSB first, stop(1), each cpb cycles long
  task automatic append_frame(input int g, input logic [BW-1:0] b, input int cpb);
    for (int k = 0; k < (BW + 2) * cpb; k++) begin
      int   pos;
      logic v;
      pos = k / cpb;
      if (pos == 0)       v = 1'b0;
      else if (pos <= BW) v = b[pos-1];
      else                v = 1'b1;
      line_mem[g][line_wp[g] % RING] = v;
      line_wp[g]++;
    end
  endtask

  task automatic clear_counts();
    for (int g = 0; g < 2; g++) begin
      busy_cnt[g] = 0;
      rd_cnt[g]   = 0;
    end
  endtask

  // one clock cycle: apply the previous edge's effects, drive, then check
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (prev_rd[g] && fifo_wp[g] != fifo_rp[g]) fifo_rp[g]++;
      if (line_rp[g] != line_wp[g]) line_rp[g]++;
      if (prev_load[g]) append_frame(g, prev_head[g], (g == 0) ? CPB_A : CPB_B);
      if (prev_rst[g]) line_rp[g] = line_wp[g];
      rst[g]   = rst_req[g];
      empty[g] = (fifo_wp[g] == fifo_rp[g]);
    end
    data_a = empty[0] ? '0 : fifo_mem[0][fifo_rp[0] % RING];
    data_b = empty[1] ? '0 : fifo_mem[1][fifo_rp[1] % RING];
    #1;
    for (int g = 0; g < 2; g++) begin
      int   len;
      logic exp_tx, exp_busy, exp_rd;
      len      = line_wp[g] - line_rp[g];
      exp_tx   = (len > 0) ? line_mem[g][line_rp[g] % RING] : 1'b1;
      exp_busy = (len > 0);
      exp_rd   = !rst[g] && (fifo_wp[g] != fifo_rp[g]) && (len <= 1);
      check_bit("uart_tx", g, tx_v[g], exp_tx);
      check_bit("busy", g, busy_v[g], exp_busy);
      check_bit("fifo_rd", g, rd_v[g], exp_rd);
      busy_cnt[g] += (busy_v[g] === 1'b1) ? 1 : 0;
      rd_cnt[g]   += (rd_v[g] === 1'b1) ? 1 : 0;
      prev_rd[g]   = (rd_v[g] === 1'b1);
      prev_load[g] = exp_rd;
      prev_head[g] = fifo_mem[g][fifo_rp[g] % RING];
      prev_rst[g]  = rst[g];
    end
    // mid-bit sampling receiver on instance B
    if (!rx_on) begin
      if (tx_b === 1'b0) begin
        rx_on   = 1'b1;
        rx_t    = 0;
        rx_byte = '0;
      end
    end else begin
      rx_t++;
      for (int i = 0; i < BW; i++)
        if (rx_t == CPB_B * (i + 1) + CPB_B / 2) rx_byte[i] = tx_b;
      if (rx_t == CPB_B * (BW + 1) + CPB_B / 2) begin
        logic [BW-1:0] exp_b;
        rx_on = 1'b0;
        rx_cnt++;
        check_bit("rx_stop", 1, tx_b, 1'b1);
        check_bit("rx_byte_expected", 1, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check_int("rx_byte", int'(rx_byte), int'(exp_b));
        end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rx_on = 1'b0; rx_t = 0; rx_cnt = 0; rx_byte = '0;
    for (int g = 0; g < 2; g++) begin
      fifo_rp[g] = 0; fifo_wp[g] = 0; line_rp[g] = 0; line_wp[g] = 0;
      prev_head[g] = '0;
    end
    rst_req = 2'b11; rst = 2'b11; empty = 2'b11;
    data_a = '0; data_b = '0;
    prev_rd = 2'b00; prev_load = 2'b00; prev_rst = 2'b11;
    clear_counts();

    // reset state
    repeat (3) tick();
    rst_req = 2'b00;

    // empty FIFO for 200 cycles: no pops, line idle
    clear_counts();
    repeat (200) tick();
    check_int("idle_rd_count", rd_cnt[0] + rd_cnt[1], 0);
    check_int("idle_busy_count", busy_cnt[0] + busy_cnt[1], 0);

    // single byte 0x55
    push(0, 8'h55);
    clear_counts();
    repeat (50) tick();
    check_int("single_rd_count", rd_cnt[0], 1);
    check_int("single_busy_cycles", busy_cnt[0], 10 * CPB_A);

    // back-to-back 0xA5, 0x3C
    push(0, 8'hA5);
    push(0, 8'h3C);
    clear_counts();
    repeat (90) tick();
    check_int("b2b_rd_count", rd_cnt[0], 2);
    check_int("b2b_busy_cycles", busy_cnt[0], 20 * CPB_A);

    // reset during data bit 3 of 0xFF, then 0x81 goes out whole
    push(0, 8'hFF);
    push(0, 8'h81);
    tick();
    repeat (18) tick();
    rst_req[0] = 1'b1;
    tick();
    rst_req[0] = 1'b0;
    clear_counts();
    repeat (50) tick();
    check_int("after_abort_rd_count", rd_cnt[0], 1);
    check_int("after_abort_busy_cycles", busy_cnt[0], 10 * CPB_A);

    // reset held with a non-empty FIFO: pop only once reset drops
    rst_req[0] = 1'b1;
    push(0, 8'h42);
    clear_counts();
    repeat (3) tick();
    check_int("rd_during_reset", rd_cnt[0], 0);
    rst_req[0] = 1'b0;
    tick();
    check_bit("rd_after_reset", 0, rd_a, 1'b1);
    repeat (45) tick();
    check_int("post_reset_busy_cycles", busy_cnt[0], 10 * CPB_A);

    // instance B: 16 random bytes at full producer rate
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      push(1, 8'($urandom_range(0, 255)));
      tick();
    end
    repeat (16 * (BW + 2) * CPB_B + 20) tick();
    check_int("rx_frames", rx_cnt, 16);
    check_int("rx_leftover", exp_q.size(), 0);
    check_int("burst_rd_count", rd_cnt[1], 16);
    check_int("burst_busy_cycles", busy_cnt[1], 16 * (BW + 2) * CPB_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_txuart.md
Name: fifo_txuart

Overview:
- Serial transmit stage that sits directly downstream of the synchronous data FIFO.
- Drains bytes from the FIFO read interface (empty flag, show-ahead data, read strobe) and shifts each byte out as an 8N1 UART frame.
- The FIFO absorbs bursts from the producer; this block sets the drain rate, so back-pressure is implicit.

Parameters:
- CLOCKS_PER_BAUD, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2 .. 2^24-1.
- BW, 8, data width; must match the FIFO data width; the frame carries BW data bits.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_fifo_empty  input  1  FIFO empty flag; data is valid when low.
- i_fifo_data  input  BW  FIFO head word, valid while i_fifo_empty is low (show-ahead).
- o_fifo_rd  output  1  combinational pop strobe; the FIFO advances on the clock edge where it is high.
- o_uart_tx  output  1  serial line, idle high.
- o_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values, applied on the clock edge where i_reset is high:
  - state IDLE, o_uart_tx 1, o_busy 0.
  - Baud counter 0, bit index 0, shift register 0.
- o_fifo_rd is forced 0 whenever i_reset is high.
- Load condition: `load = !i_reset && !i_fifo_empty && (state==IDLE || (state==STOP && baud_cnt==1))`.
  - o_fifo_rd = load.
  - o_fifo_rd is never high while i_fifo_empty is high.
- On a load edge:
  - shift register <= i_fifo_data.
  - state <= START, baud_cnt <= CLOCKS_PER_BAUD, o_uart_tx <= 0.
- Baud counter: decrements by 1 every cycle outside IDLE. The bit period ends on the cycle where baud_cnt==1; the next edge reloads CLOCKS_PER_BAUD and advances state.
- State machine:
  - IDLE: line 1; stays in IDLE while the FIFO is empty.
  - START: line 0 for CLOCKS_PER_BAUD cycles, then DATA with bit index 0; line <= shreg[0].
  - DATA: LSB first. At the end of each bit period, shift right; bit index increments; line <= next bit. After bit BW-1 ends: STOP, line 1.
  - STOP: line 1 for CLOCKS_PER_BAUD cycles. At the end of the period:
    - if load, go to START immediately (zero idle gap between back-to-back frames);
    - otherwise go to IDLE.
- Latency:
  - From IDLE with a non-empty FIFO, o_fifo_rd asserts in the same cycle (cycle T).
  - The start bit appears on o_uart_tx from cycle T+1.
  - Frame length is exactly (BW+2)*CLOCKS_PER_BAUD cycles.
- o_uart_tx is driven from a register (glitch-free); only o_fifo_rd is combinational.
- The FIFO going empty/non-empty mid-frame has no effect until the next load point.
- A newly written byte arriving while IDLE is popped on the first cycle i_fifo_empty is low.
- Reset mid-frame:
  - o_uart_tx returns to 1 on the reset edge; the partial frame is aborted.
  - The popped byte is discarded and not re-fetched.
  - FIFO contents are untouched by this block.
- Simultaneous reset and non-empty FIFO: no pop that cycle; the pop occurs on the first cycle after reset deasserts.
- Counter width is clog2(CLOCKS_PER_BAUD+1); bit index width is clog2(BW+1); no wrap-around is reachable.

Test Plan:
- CLOCKS_PER_BAUD=4, FIFO holds 0x55 -> o_fifo_rd high for 1 cycle; line shows 0 (4 clks), 1,0,1,0,1,0,1,0 (4 clks each), 1 (4 clks); o_busy high for exactly 40 cycles; then IDLE.
- CLOCKS_PER_BAUD=4, FIFO holds 0xA5,0x3C -> second o_fifo_rd on the last cycle of the first stop bit; start bit of 0x3C begins the next cycle (no gap); decoded bytes 0xA5,0x3C; total 80 cycles of o_busy.
- FIFO empty for 200 cycles -> o_fifo_rd never high, o_uart_tx constant 1, o_busy 0.
- CLOCKS_PER_BAUD=4, byte 0xFF, i_reset pulsed during data bit 3 -> next cycle o_uart_tx=1, o_busy=0; the following FIFO byte 0x81 is then sent as a complete, correct frame.
- CLOCKS_PER_BAUD=2, 16 random bytes written by the FIFO producer at full rate until FIFO full -> a receiver model sampling at mid-bit recovers all 16 bytes in order; no pop while empty.
- i_reset high while FIFO non-empty -> o_fifo_rd low throughout reset; it rises in the first cycle after reset deasserts.
